display_arbiter: RTL

Shares the four-digit seven-segment display path between several requesters, for example operand entry, result and error status. Only one requester owns the display at a time. The block grants ownership with a round-robin request/grant handshake, a minimum on-screen hold time and immediate preemption by requester 0 (error). It sits directly upstream of the display driver. It drives the driver's 16-bit BCD data word and a blanking control, and is paced by a slow tick taken from the clock ladder.

---
 rtl/display_arbiter_pkg.sv | 17 +
 rtl/display_arbiter_if.sv | 23 ++
 rtl/display_arbiter_rr_picker.sv | 28 ++
 rtl/display_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared types and default constants for the display arbiter slice.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    localparam int NREQ_DEF        = 3;
    localparam int HOLD_TICKS_DEF  = 8;
    localparam int BLINK_TICKS_DEF = 4;
    localparam int DIGIT_W         = 4;
    localparam int WORD_W          = 4 * DIGIT_W;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/display_arbiter_if.sv
// Requester-side bus of the display arbiter: requests and BCD words in, owner and display word out.
interface display_arbiter_if
    import disp_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]        req;
    logic [WORD_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        grant;
    logic [WORD_W-1:0]      disp_data;
    logic                   disp_valid;
    logic                   disp_blank;

    modport master (
        output req, req_data,
        input  grant, disp_data, disp_valid, disp_blank
    );

    modport slave (
        input  req, req_data,
        output grant, disp_data, disp_valid, disp_blank
    );
endinterface

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above rr_ptr, wrapping modulo NREQ.
module rr_picker
    import disp_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = $clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner,
    output logic             found
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner arbiter for the seven-segment display path with hold time and urgent preemption.
// Optional blinking of an urgent owner is compiled in with `DISP_ARB_BLINK_EN.
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    display_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);

    if (NREQ < 2 || NREQ > 8 || HOLD_TICKS < 1 || HOLD_TICKS > 255 ||
        BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_param
        $error("display_arbiter: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [NREQ-1:0]   pick_req, pick_win, new_grant;
    logic              pick_found, grant_event, preempt, owner_req;

    function automatic logic [WORD_W-1:0] word_of(input logic [NREQ-1:0] sel,
                                                  input logic [WORD_W*NREQ-1:0] words);
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < NREQ; k++)
            if (sel[k]) w |= words[k*WORD_W +: WORD_W];
        return w;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [NREQ-1:0] sel);
        logic [PTR_W-1:0] p = '0;
        for (int k = 0; k < NREQ; k++)
            if (sel[k]) p = PTR_W'((k + 1) % NREQ);
        return p;
    endfunction

    // While someone owns the display, the owner itself is excluded from the search.
    assign pick_req  = (state_q == IDLE) ? bus.req : (bus.req & ~grant_q);
    assign owner_req = |(bus.req & grant_q);
    assign preempt   = (state_q != IDLE) && bus.req[0] && !grant_q[0];

    rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
        .req    (pick_req),
        .rr_ptr (ptr_q),
        .winner (pick_win),
        .found  (pick_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_event = 1'b0;
        new_grant   = '0;
        if (preempt) begin
            state_d     = HOLD;
            grant_event = 1'b1;
            new_grant   = NREQ'(1);
        end else begin
            unique case (state_q)
                IDLE: if (|bus.req) begin
                    state_d     = HOLD;
                    grant_event = 1'b1;
                    new_grant   = bus.req[0] ? NREQ'(1) : pick_win;
                end
                HOLD: if (tick && hold_q <= CNT_W'(1)) state_d = OPEN;
                OPEN: if (pick_found) begin
                    state_d     = HOLD;
                    grant_event = 1'b1;
                    new_grant   = pick_win;
                end else if (!owner_req) begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        grant_d = grant_q;
        data_d  = data_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        valid_d = (state_d != IDLE);
        if (grant_event) begin
            grant_d = new_grant;
            data_d  = word_of(new_grant, bus.req_data);
            hold_d  = HOLD_LOAD;
            // An urgent interruption must not disturb the rotation it interrupted.
            if (!preempt) ptr_d = ptr_after(new_grant);
        end else if (state_d == IDLE) begin
            grant_d = '0;
            data_d  = '0;
            hold_d  = '0;
        end else begin
            if (owner_req) data_d = word_of(grant_q, bus.req_data);
            if (state_q == HOLD && tick && hold_q != '0) hold_d = hold_q - CNT_W'(1);
        end
    end

    assign bus.grant      = grant_q;
    assign bus.disp_data  = data_q;
    assign bus.disp_valid = valid_q;

`ifdef DISP_ARB_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

    logic             blank_q;
    logic [CNT_W-1:0] blink_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_q <= 1'b0;
            blink_q <= '0;
        end else if (!grant_d[0] || grant_event) begin
            blank_q <= 1'b0;
            blink_q <= '0;
        end else if (tick) begin
            if (blink_q == BLINK_LAST) begin
                blank_q <= ~blank_q;
                blink_q <= '0;
            end else begin
                blink_q <= blink_q + CNT_W'(1);
            end
        end
    end

    assign bus.disp_blank = blank_q;
`else
    assign bus.disp_blank = 1'b0;
`endif
endmodule
